wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_port_arbiter_if.sv | 38 +++
 rtl/wb_hold_buf.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Used by wb_port_arbiter, wb_hold_buf and wb_port_arbiter_if.
package wb_arb_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side bus of the arbiter: pipeline request, MDU offer, RF write port.
// The slave modport is the arbiter's view; master is the surrounding core.
interface wb_port_arbiter_if #(
  parameter int XLEN = wb_arb_pkg::XLEN_DEFAULT
) ();

  logic                              pipe_wr_en;
  logic [wb_arb_pkg::REG_ADDR_W-1:0] pipe_wr_addr;
  logic [XLEN-1:0]                   pipe_wr_data;

  logic                              mdu_valid;
  logic [wb_arb_pkg::REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]                   mdu_data;
  logic                              mdu_ready;

  logic                              rf_we;
  logic [wb_arb_pkg::REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]                   rf_wdata;

  logic                              pipe_stall;

  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output pipe_stall
  );

  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  pipe_stall
  );

endinterface

// File: rtl/wb_hold_buf.sv
// Single-entry buffer for a deferred MDU result, with the write-after-write
// address compare the arbiter uses to squash a stale entry.
module wb_hold_buf
  import wb_arb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [XLEN-1:0]       load_data,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] cmp_addr,
  output logic [REG_ADDR_W-1:0] buf_rd,
  output logic [XLEN-1:0]       buf_data,
  output logic                  waw_hit
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;

  // Load only happens from an empty buffer, so it never races a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      rd_q    <= load_rd;
      data_q  <= load_data;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign buf_rd   = rd_q;
  assign buf_data = data_q;
  assign waw_hit  = valid_q && (cmp_addr == rd_q);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the main pipeline and a
// buffered MDU result. Optional feature: WB_WAW_SQUASH_EN (younger write squashes buffer).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  wb_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e state_q, state_d;

  logic [CNT_W-1:0]      starve_cnt_q;
  logic                  pipe_eff;
  logic                  cnt_hit;
  logic                  squash;
  logic                  waw_hit;
  logic                  grant_pipe;
  logic                  grant_buf;
  logic                  buf_load;
  logic                  buf_clear;
  logic                  mdu_ready_c;
  logic                  pipe_stall_c;
  logic [REG_ADDR_W-1:0] buf_rd;
  logic [XLEN-1:0]       buf_data;

  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;

  assign pipe_eff = bus.pipe_wr_en && (bus.pipe_wr_addr != '0);
  assign cnt_hit  = (starve_cnt_q + CNT_W'(1)) == LIMIT_C;

`ifdef WB_WAW_SQUASH_EN
  assign squash = (state_q == ST_HOLD) && pipe_eff && waw_hit;
`else
  logic unused_waw_hit;
  assign unused_waw_hit = waw_hit;
  assign squash         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Squash beats the starvation check: a dropped entry has nothing left to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (buf_load) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (squash || !pipe_eff) state_d = ST_IDLE;
        else if (cnt_hit)        state_d = ST_FORCE;
      end
      ST_FORCE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mdu_ready_c  = 1'b0;
    pipe_stall_c = 1'b0;
    grant_pipe   = 1'b0;
    grant_buf    = 1'b0;
    buf_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mdu_ready_c = 1'b1;
        grant_pipe  = pipe_eff;
        buf_load    = bus.mdu_valid && (bus.mdu_rd != '0);
      end
      ST_HOLD: begin
        grant_pipe = pipe_eff;
        grant_buf  = !pipe_eff;
      end
      ST_FORCE: begin
        pipe_stall_c = 1'b1;
        grant_buf    = 1'b1;
      end
      default: ;
    endcase
  end

  assign buf_clear = grant_buf || squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (buf_clear) begin
      starve_cnt_q <= '0;
    end else if ((state_q == ST_HOLD) && grant_pipe) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end

  // Address and data keep their last value when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= grant_pipe || grant_buf;
      if (grant_pipe) begin
        rf_waddr_q <= bus.pipe_wr_addr;
        rf_wdata_q <= bus.pipe_wr_data;
      end else if (grant_buf) begin
        rf_waddr_q <= buf_rd;
        rf_wdata_q <= buf_data;
      end
    end
  end

  wb_hold_buf #(.XLEN(XLEN)) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_rd   (bus.mdu_rd),
    .load_data (bus.mdu_data),
    .clear     (buf_clear),
    .cmp_addr  (bus.pipe_wr_addr),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data),
    .waw_hit   (waw_hit)
  );

  assign bus.mdu_ready  = mdu_ready_c;
  assign bus.pipe_stall = pipe_stall_c;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;

endmodule
